rope_controller: RTL

Sequencer for the player's rope (harpoon). It accepts fire requests and latches the rope's X column from the player position. Once per video frame it advances the rope tip from the floor toward the ceiling, and it ends the shot on a ball hit, on reaching the ceiling, or when a super-rope hold expires. Its outputs feed the rope square/bitmap drawing path (top-left X/Y, height, super-rope colour select) and the game-state logic.

---
 rtl/rope_pkg.sv | 18 +
 rtl/rope_charge_counter.sv | 30 +++
 rtl/rope_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/rope_pkg.sv
// Shared rope types and default geometry, also used by the rope drawing and
// collision blocks.
package rope_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXTEND = 2'd1,
        STUCK  = 2'd2
    } rope_state_t;

    localparam logic [10:0] ROPE_FLOOR_Y       = 11'd440;
    localparam logic [10:0] ROPE_CEILING_Y     = 11'd16;
    localparam logic [10:0] ROPE_SPEED         = 11'd4;
    localparam logic [10:0] ROPE_X_OFFSET_DEF  = 11'd12;
    localparam logic [7:0]  ROPE_STUCK_FRAMES  = 8'd120;
    localparam logic [1:0]  ROPE_MAX_CHARGES   = 2'd3;

endpackage

// File: rtl/rope_charge_counter.sv
// Saturating 2-bit super-rope charge counter; simultaneous inc and dec cancel.
module rope_charge_counter #(
    parameter logic [1:0] MAX_CHARGES = 2'd3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] count
);

    logic [1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({inc, dec})
            2'b10:   if (count_q != MAX_CHARGES) count_d = count_q + 2'd1;
            2'b01:   if (count_q != 2'd0)        count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) count_q <= 2'd0;
        else         count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/rope_controller.sv
// Rope (harpoon) sequencer: launches on a fire edge, climbs once per frame,
// and ends on a ball hit, the ceiling, or expiry of a super-rope hold.
module rope_controller
    import rope_pkg::*;
#(
    parameter logic [10:0] FLOOR_Y       = ROPE_FLOOR_Y,
    parameter logic [10:0] CEILING_Y     = ROPE_CEILING_Y,
    parameter logic [10:0] SPEED         = ROPE_SPEED,
    parameter logic [10:0] ROPE_X_OFFSET = ROPE_X_OFFSET_DEF,
    parameter logic [7:0]  STUCK_FRAMES  = ROPE_STUCK_FRAMES,
    parameter logic [1:0]  MAX_CHARGES   = ROPE_MAX_CHARGES
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic [10:0] playerX,
    input  logic        superBonus,
    input  logic        ropeHit,
    output logic [10:0] ropeTopX,
    output logic [10:0] ropeTopY,
    output logic [10:0] ropeHeight,
    output logic        ropeActive,
    output logic        superRope,
    output logic        ropeDone,
    output logic [1:0]  charges
);

    rope_state_t state_q;
    logic [10:0] topx_q, topy_q;
    logic [7:0]  stuck_q;
    logic        fire_q, super_q, done_q;
    logic        fire_edge, launch, consume;

    assign fire_edge = fire & ~fire_q;
    assign launch    = (state_q == IDLE) && fire_edge;
    assign consume   = launch && (charges != 2'd0);

    rope_charge_counter #(.MAX_CHARGES(MAX_CHARGES)) u_charges (
        .clk   (clk),
        .resetN(resetN),
        .inc   (superBonus),
        .dec   (consume),
        .count (charges)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            topx_q  <= 11'd0;
            topy_q  <= FLOOR_Y;
            stuck_q <= 8'd0;
            fire_q  <= 1'b0;
            super_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fire_q <= fire;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    super_q <= 1'b0;
                    if (fire_edge) begin
                        topx_q  <= playerX + ROPE_X_OFFSET;
                        topy_q  <= FLOOR_Y;
                        super_q <= (charges != 2'd0);
                        state_q <= EXTEND;
                    end
                end
                EXTEND: begin
                    // A hit wins over the frame step; the tip freezes where it was.
                    if (ropeHit) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (startOfFrame) begin
                        if (topy_q <= CEILING_Y + SPEED) begin
                            topy_q <= CEILING_Y;
                            if (super_q) begin
                                state_q <= STUCK;
                                stuck_q <= 8'd0;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            topy_q <= topy_q - SPEED;
                        end
                    end
                end
                STUCK: begin
                    if (ropeHit) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (startOfFrame) begin
                        if (stuck_q == STUCK_FRAMES - 8'd1) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            stuck_q <= stuck_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ropeTopX   = topx_q;
    assign ropeTopY   = topy_q;
    assign ropeHeight = FLOOR_Y - topy_q;
    assign ropeActive = (state_q != IDLE);
    assign superRope  = super_q;
    assign ropeDone   = done_q;

endmodule
